// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle radix-2 restoring divider and sequencer for DIV/DIVU
//
// Purpose: owns the single divider datapath used by DIV/DIVU in EX. It latches
// the operands when a request is accepted, iterates one quotient bit per cycle,
// presents {remainder, quotient} with ready_o, and stalls the pipeline meanwhile.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start_i    divide request from EX, held until the result is consumed
//   signed_i   1 = DIV (two's complement), 0 = DIVU
//   annul_i    cancel the current or pending divide
//   opdata1_i  dividend
//   opdata2_i  divisor
//   result_o   {remainder, quotient}; zero outside END
//   ready_o    result valid
//   stallreq_o pipeline stall request (combinational)
module div_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     dvd_q;      // dividend, shifted out as quotient bits shift in
  logic [DATA_W-1:0]     dvs_q;
  logic [DATA_W-1:0]     rem_q;
  logic                  neg_a_q;
  logic                  neg_b_q;
  logic                  signed_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  ready_q;

  logic                  accept_d;
  logic [DATA_W-1:0]     op1_abs_d;
  logic [DATA_W-1:0]     op2_abs_d;
  logic [DATA_W:0]       rem_sh_d;
  logic [DATA_W:0]       trial_d;
  logic                  qbit_d;
  logic [DATA_W-1:0]     rem_nx_d;
  logic [DATA_W-1:0]     quo_nx_d;
  logic [DATA_W-1:0]     quo_fix_d;
  logic [DATA_W-1:0]     rem_fix_d;

  assign accept_d  = start_i && !annul_i;

  assign op1_abs_d = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs_d = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Partial remainder always stays below the divisor, so one extra bit is
  // enough for the trial subtraction: its MSB is the borrow.
  assign rem_sh_d  = {rem_q, dvd_q[DATA_W-1]};
  assign trial_d   = rem_sh_d - {1'b0, dvs_q};
  assign qbit_d    = ~trial_d[DATA_W];
  assign rem_nx_d  = qbit_d ? trial_d[DATA_W-1:0] : rem_sh_d[DATA_W-1:0];
  assign quo_nx_d  = {dvd_q[DATA_W-2:0], qbit_d};

  // Sign correction: quotient follows sign(a)^sign(b), remainder follows sign(a).
  assign quo_fix_d = (signed_q && (neg_a_q ^ neg_b_q)) ? -quo_nx_d : quo_nx_d;
  assign rem_fix_d = (signed_q && neg_a_q) ? -rem_nx_d : rem_nx_d;

  assign stallreq_o = ((state_q == S_IDLE) && accept_d) ||
                      (state_q == S_ON) || (state_q == S_DIVZERO);
  assign result_o   = result_q;
  assign ready_o    = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      signed_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            if (opdata2_i == '0) begin
              state_q <= S_DIVZERO;
              dvd_q   <= opdata1_i;   // raw dividend is the divide-by-zero remainder
            end else begin
              state_q  <= S_ON;
              dvd_q    <= op1_abs_d;
              dvs_q    <= op2_abs_d;
              neg_a_q  <= signed_i && opdata1_i[DATA_W-1];
              neg_b_q  <= signed_i && opdata2_i[DATA_W-1];
              signed_q <= signed_i;
              rem_q    <= '0;
              cnt_q    <= '0;
            end
          end
        end
        S_DIVZERO: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            state_q  <= S_END;
            result_q <= {dvd_q, {DATA_W{1'b1}}};
            ready_q  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            dvd_q <= quo_nx_d;
            rem_q <= rem_nx_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q  <= S_END;
              result_q <= {rem_fix_d, quo_fix_d};
              ready_q  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle 32-bit radix-2 restoring divider and sequencer for DIV/DIVU in the EX stage.
- EX raises start_i with operands and holds it. The block drives stallreq_o to freeze the pipeline until the quotient and remainder are ready.
- EX then writes the result toward HI/LO.
- The block owns the only divider datapath. Its FSM serialises use of that datapath and handles annulment when the EX instruction is squashed.

Parameters:
DATA_W, 32, operand width; result_o is 2*DATA_W
CNT_W, 6, iteration counter width; must hold the value DATA_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
start_i  input  1  divide request from EX; held high until EX consumes the result
signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
annul_i  input  1  cancel current or pending divide (EX instruction squashed)
opdata1_i  input  DATA_W  dividend; sampled when start is accepted
opdata2_i  input  DATA_W  divisor; sampled when start is accepted
result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1
ready_o  output  1  result valid
stallreq_o  output  1  pipeline stall request to the stall controller

Behaviour:
- Reset (rst=1 at a clock edge) from any state:
  - state returns to IDLE, counter=0, working registers=0.
  - result_o=0, ready_o=0.
  - stallreq_o=0 in the following cycle.
- result_o and ready_o are registered. stallreq_o is combinational.
- stallreq_o is 1 in exactly two cases:
  - (state==IDLE && start_i && !annul_i), so the stall applies in the request cycle itself.
  - state is ON or DIVZERO.
- stallreq_o is 0 in all other cases, including END.
- FSM states: IDLE, DIVZERO, ON, END.
- IDLE:
  - Start is accepted when start_i=1 and annul_i=0.
  - If the divisor is 0, go to DIVZERO.
  - Otherwise go to ON. Latch |dividend| and |divisor| (absolute values only when signed_i=1), the sign flags, and signed_i. Clear the partial remainder and set counter=0.
  - Otherwise stay in IDLE.
- ON: one iteration per cycle.
  - Shift {partial remainder, dividend} left by 1.
  - Compute trial = partial remainder - divisor at DATA_W+1 bits.
  - If trial is non-negative, the partial remainder becomes trial and quotient bit = 1. Otherwise quotient bit = 0.
  - counter increments each cycle.
  - When the iteration with counter==DATA_W-1 completes, go to END and register the corrected result:
    - quotient is negated if the two signs differ (signed only).
    - remainder is negated if the dividend was negative (signed only).
  - If annul_i=1 in ON, go to IDLE next edge. No result is produced and ready_o stays 0.
- DIVZERO: go to END with quotient=all ones and remainder=dividend unmodified. annul_i=1 here goes to IDLE instead.
- END:
  - ready_o=1 and result_o holds steady.
  - Stay in END while start_i=1 && annul_i=0.
  - On start_i=0 or annul_i=1, go to IDLE and clear result_o and ready_o to 0 at the same edge.
- Latency, with start accepted at the edge ending cycle N:
  - Normal divide: ON in cycles N+1..N+32, ready_o=1 from cycle N+33. stallreq_o is high in cycles N..N+32 and low in N+33.
  - Divide by zero: DIVZERO in N+1, ready_o=1 from N+2.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (natural wrap, no trap).
- Simultaneous events:
  - rst overrides everything.
  - annul_i overrides start_i in every state.
  - A new start is accepted only from IDLE, so back-to-back divides need one IDLE cycle after END.
- Outside END, result_o is 0.

Test Plan:
- DIVU 100/7, start held: stallreq_o=1 cycles N..N+32; at N+33 ready_o=1, result_o={32'd2, 32'd14}, stallreq_o=0. Drop start gives ready_o=0 and result_o=0 next cycle.
- DIV 0xFFFFFFF9 (-7) / 2: result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / 0xFFFFFFFE: {0x00000001, 0xFFFFFFFD}. DIVU 0xFFFFFFFF/1: {0, 0xFFFFFFFF}.
- DIV 0x80000000/0xFFFFFFFF: result_o={0, 0x80000000}, latency 33.
- DIVU 0x1234/0: ready_o=1 at N+2 with result_o={0x00001234, 0xFFFFFFFF}. stallreq_o high only N..N+1.
- annul_i pulsed at N+10 during ON: state IDLE at N+11, stallreq_o=0, ready_o never asserts. A fresh DIVU 9/3 then yields {0, 3} at 33-cycle latency.
- rst asserted at N+5 during ON: next cycle result_o=0, ready_o=0, stallreq_o=0 (start_i low). start_i held high with annul_i=0 restarts at 33-cycle latency.
